// File: rtl/router_pkg.sv
// Shared router definitions: sizing, packet field layout and arbiter state encoding.
// Packets are indexed [0:PL-1] with bit 0 = valid, then X, Y, payload.
package router_pkg;

  localparam int unsigned REN       = 5;
  localparam int unsigned CS        = 2;
  localparam int unsigned PL        = 1 + 2 * CS + 3;
  localparam int unsigned IDW       = $clog2(REN);

  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned X_LSB     = 1;
  localparam int unsigned X_MSB     = CS;
  localparam int unsigned Y_LSB     = CS + 1;
  localparam int unsigned Y_MSB     = 2 * CS;
  localparam int unsigned PAY_LSB   = 2 * CS + 1;
  localparam int unsigned PAY_MSB   = PL - 1;

  typedef logic [0:PL-1] packet_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Port index following idx, wrapping back to port 0.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    return (idx == IDW'(REN - 1)) ? '0 : idx + IDW'(1);
  endfunction

endpackage

// File: rtl/router_input_arbiter_rr_select.sv
// Combinational round-robin picker: first eligible requester at or after ptr, modulo N.
// Assumes ptr < N.
module rr_select
  import router_pkg::*;
#(
  parameter int unsigned N  = REN,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!any_c && eligible[cand]) begin
        grant_c[cand] = 1'b1;
        idx_c         = cand;
        any_c         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_input_arbiter.sv
// Round-robin arbiter feeding the single routing-algorithm stage from REN input ports.
// Holds the granted packet until out_ready; discards it after TIMEOUT stalled cycles.
module router_input_arbiter
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  packet_t [0:REN-1]   in_packet,
  input  logic    [REN-1:0]   in_req,
  output logic    [REN-1:0]   in_ack,
  input  logic                out_ready,
  output packet_t             to_algorithm,
  output logic    [IDW-1:0]   grant_id,
  output logic                drop
);

  localparam int unsigned SW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = (TIMEOUT > 0) ? SW'(TIMEOUT - 1) : '0;

  state_e          state_q, state_d;
  packet_t         pkt_d;
  logic [IDW-1:0]  gid_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            drop_d;
  logic            take;
  logic            timeout_hit;

  logic [REN-1:0]  eligible;
  logic [REN-1:0]  sel_grant;
  logic [IDW-1:0]  sel_idx;
  logic            sel_any;

  // A request is only eligible when the offered packet is marked valid.
  for (genvar g = 0; g < REN; g++) begin : g_elig
    assign eligible[g] = in_req[g] & in_packet[g][VALID_BIT];
  end

  rr_select #(
    .N  (REN),
    .IW (IDW)
  ) u_rr_select (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant_c  (sel_grant),
    .idx_c    (sel_idx),
    .any_c    (sel_any)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == STALL_LAST);
  assign in_ack      = (take && !rst) ? sel_grant : '0;

  // Next-state, holding register and stall counter update.
  always_comb begin
    state_d = state_q;
    pkt_d   = to_algorithm;
    gid_d   = grant_id;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        take = sel_any;
      end
      BUSY: begin
        if (out_ready) begin
          if (sel_any) begin
            take = 1'b1;
          end else begin
            pkt_d   = '0;
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          // Drop cycle never grants; a new grant can follow next cycle.
          pkt_d   = '0;
          drop_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + SW'(1);
        end
      end
    endcase

    if (take) begin
      pkt_d   = in_packet[sel_idx];
      gid_d   = sel_idx;
      ptr_d   = wrap_inc(sel_idx);
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      to_algorithm <= '0;
      grant_id     <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      drop         <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_algorithm <= pkt_d;
      grant_id     <= gid_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      drop         <= drop_d;
    end
  end

endmodule

// File: tb/tb_router_input_arbiter.sv
// Scoreboard bench for router_input_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_router_input_arbiter;
  import router_pkg::*;

  localparam int unsigned TO  = 4;
  localparam int unsigned SWB = (TO > 0) ? $clog2(TO + 1) : 1;
  localparam int          SAT = (1 << SWB) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  packet_t [0:REN-1] in_packet;
  logic [REN-1:0]    in_req;
  logic [REN-1:0]    in_ack;
  logic              out_ready;
  packet_t           to_algorithm;
  logic [IDW-1:0]    grant_id;
  logic              drop;

  router_input_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_packet    (in_packet),
    .in_req       (in_req),
    .in_ack       (in_ack),
    .out_ready    (out_ready),
    .to_algorithm (to_algorithm),
    .grant_id     (grant_id),
    .drop         (drop)
  );

  typedef struct packed {
    packet_t        pkt;
    logic [IDW-1:0] gid;
    logic           drp;
    logic [REN-1:0] ack;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: is a packet held, which one, from whom, where the scan starts.
  bit      m_held;
  packet_t m_pkt;
  int      m_gid;
  int      m_ptr;
  int      m_stall;
  bit      m_drop;

  task automatic model_reset();
    m_held  = 1'b0;
    m_pkt   = '0;
    m_gid   = 0;
    m_ptr   = 0;
    m_stall = 0;
    m_drop  = 1'b0;
  endtask

  function automatic packet_t rand_pkt(input int pvalid);
    packet_t p;
    p    = PL'($urandom);
    p[0] = (int'($urandom_range(99)) < pvalid);
    return p;
  endfunction

  task automatic cycle(input logic r, input logic [REN-1:0] rq,
                       input packet_t [0:REN-1] pk, input logic rdy);
    exp_t           e;
    int             sel;
    logic [IDW-1:0] si;
    bit             accept;
    @(posedge clk);
    #1;
    rst       = r;
    in_req    = rq;
    in_packet = pk;
    out_ready = rdy;
    cyc++;

    sel = -1;
    si  = '0;
    for (int k = 0; k < int'(REN); k++) begin
      logic [IDW-1:0] pi;
      pi = IDW'((m_ptr + k) % int'(REN));
      if (sel < 0 && rq[pi] && pk[pi][0]) begin
        sel = int'(pi);
        si  = pi;
      end
    end
    accept = !m_held || rdy;

    e.pkt = m_held ? m_pkt : '0;
    e.gid = IDW'(m_gid);
    e.drp = m_drop;
    e.ack = (!r && accept && sel >= 0) ? (REN'(1) << sel) : '0;
    sb.push_back(e);

    m_drop = 1'b0;
    if (r) begin
      model_reset();
    end else if (m_held && !rdy) begin
      if (TO > 0 && m_stall == int'(TO) - 1) begin
        m_held = 1'b0;
        m_pkt  = '0;
        m_drop = 1'b1;
      end else if (m_stall < SAT) begin
        m_stall++;
      end
    end else if (sel >= 0) begin
      m_held  = 1'b1;
      m_pkt   = pk[si];
      m_gid   = sel;
      m_ptr   = (sel + 1) % int'(REN);
      m_stall = 0;
    end else begin
      m_held = 1'b0;
      m_pkt  = '0;
    end
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests += 4;
      if (to_algorithm !== e.pkt) begin
        fails++;
        $display("FAIL to_algorithm cyc=%0d got=%b exp=%b", cyc, to_algorithm, e.pkt);
      end
      if (grant_id !== e.gid) begin
        fails++;
        $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, e.gid);
      end
      if (drop !== e.drp) begin
        fails++;
        $display("FAIL drop cyc=%0d got=%b exp=%b", cyc, drop, e.drp);
      end
      if (in_ack !== e.ack) begin
        fails++;
        $display("FAIL in_ack cyc=%0d got=%b exp=%b", cyc, in_ack, e.ack);
      end
    end
  end

  initial begin
    packet_t [0:REN-1] pk;
    logic [REN-1:0]    rq;
    int                prdy;

    rst       = 1'b1;
    in_req    = '0;
    in_packet = '0;
    out_ready = 1'b0;
    model_reset();
    pk = '0;

    cycle(1'b1, '0, pk, 1'b0);
    cycle(1'b1, '0, pk, 1'b0);

    // Single packet from port 2.
    pk[2] = 8'b1_01_10_101;
    cycle(1'b0, 5'b00100, pk, 1'b1);
    cycle(1'b0, 5'b00000, pk, 1'b1);
    cycle(1'b0, 5'b00000, pk, 1'b1);

    // Fairness: everyone requests, downstream always ready.
    cycle(1'b1, '0, pk, 1'b1);
    for (int i = 0; i < int'(REN); i++) pk[i] = rand_pkt(100);
    for (int i = 0; i < 12; i++) cycle(1'b0, 5'b11111, pk, 1'b1);
    cycle(1'b0, 5'b00000, pk, 1'b1);

    // Backpressure: port 1 held while ports 3 and 4 wait.
    cycle(1'b1, '0, pk, 1'b1);
    cycle(1'b0, 5'b00010, pk, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'b11000, pk, 1'b0);
    cycle(1'b0, 5'b11000, pk, 1'b1);
    cycle(1'b0, 5'b10000, pk, 1'b1);
    cycle(1'b0, 5'b00000, pk, 1'b1);

    // Timeout: port 0 stalls until dropped, port 1 pending.
    cycle(1'b1, '0, pk, 1'b0);
    cycle(1'b0, 5'b00001, pk, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 5'b00010, pk, 1'b0);
    cycle(1'b0, 5'b00000, pk, 1'b1);
    cycle(1'b0, 5'b00000, pk, 1'b1);

    // Malformed request from port 4, then reset while busy.
    cycle(1'b1, '0, pk, 1'b1);
    pk[4][0] = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 5'b10000, pk, 1'b1);
    cycle(1'b0, 5'b10100, pk, 1'b0);
    cycle(1'b0, 5'b10000, pk, 1'b0);
    cycle(1'b1, 5'b10000, pk, 1'b0);
    cycle(1'b0, 5'b01001, pk, 1'b1);
    cycle(1'b0, 5'b00000, pk, 1'b1);

    // Randomized traffic with alternating backpressure intensity.
    for (int i = 0; i < 3000; i++) begin
      prdy = ((i / 200) % 2 == 0) ? 30 : 90;
      for (int j = 0; j < int'(REN); j++) pk[j] = rand_pkt(85);
      rq = REN'($urandom);
      cycle(($urandom_range(99) == 0), rq, pk,
            (int'($urandom_range(99)) < prdy));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
